// File: rtl/band_scan.sv
// band_scan: classifies one scan row per frame into resistor colour codes and
// reports the first three run-length-filtered bands, left to right.
module band_scan #(
  parameter int SCAN_ROW = 360,
  parameter int MIN_RUN  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] data_i,
  input  logic        vde_i,
  input  logic        hsync_i,
  input  logic        vsync_i,
  output logic [3:0]  band0_o,
  output logic [3:0]  band1_o,
  output logic [3:0]  band2_o,
  output logic [1:0]  band_cnt_o,
  output logic        valid_o
);
  localparam logic [2:0] IDLE = 3'd0, WAIT_ROW = 3'd1, SCAN = 3'd2, FLUSH = 3'd3, REPORT = 3'd4;
  localparam logic [11:0] ROW = 12'(SCAN_ROW);
  localparam logic [7:0] RUN_HIT = 8'(MIN_RUN - 1);
  logic [7:0] r, g, b, lum, mx, mn;
  logic r_dom, g_dom;
  logic [3:0] code_d, code_q, cur_d, cur_q, last_d, last_q;
  logic [3:0] s0_d, s0_q, s1_d, s1_q, s2_d, s2_q;
  logic [1:0] cnt_d, cnt_q;
  logic [7:0] run_d, run_q;
  logic [2:0] state_d, state_q;
  logic [11:0] row_d, row_q, col_d, col_q;
  logic vld_d, vld_q, vde_q, vs_q, fl_d, fl_q;
  logic vs_rise, vde_fall, start, same, hit;
  always_comb begin
    {r, b, g} = data_i;
    lum = 8'((10'(r) + {1'b0, g, 1'b0} + 10'(b)) >> 2);
    r_dom = r >= g && r >= b;
    g_dom = !r_dom && g >= b;
    mx = r_dom ? r : g_dom ? g : b;
    mn = (r <= g && r <= b) ? r : (g <= b) ? g : b;
    code_d = (mx - mn < 8'd32) ? (lum < 8'd48 ? 4'd0 : lum < 8'd160 ? 4'd8 : lum < 8'd224 ? 4'd9 : 4'd15)
           : r_dom ? (({1'b0, g} + 9'd32 >= {1'b0, r}) ? 4'd4
                    : ({1'b0, g} >= {1'b0, b} + 9'd48) ? 4'd3
                    : (lum < 8'd96) ? 4'd1 : 4'd2)
           : g_dom ? 4'd5
           : ({1'b0, r} >= {1'b0, g} + 9'd32) ? 4'd7 : 4'd6;
  end
  always_comb begin
    vs_rise = vsync_i & ~vs_q;
    vde_fall = vde_q & ~vde_i;
    start = state_q == WAIT_ROW && !vs_rise && row_q == ROW && vde_i;
    vld_d = vde_i & ~hsync_i & (state_q == SCAN || start);
    col_d = vde_i ? col_q + 12'd1 : 12'd0;
    row_d = vs_rise ? 12'd0 : vde_fall ? row_q + 12'd1 : row_q;
    state_d = state_q;
    fl_d = 1'b0;
    case (state_q)
      IDLE:     state_d = vs_rise ? WAIT_ROW : IDLE;
      WAIT_ROW: state_d = start ? SCAN : WAIT_ROW;
      SCAN:     state_d = vs_rise ? WAIT_ROW : vde_fall ? FLUSH : SCAN;
      FLUSH: begin
        fl_d = 1'b1;
        state_d = fl_q ? REPORT : FLUSH;
      end
      default:  state_d = IDLE;
    endcase
    // a band is accepted exactly once, on the cycle its run reaches MIN_RUN
    same = code_q == cur_q;
    hit = vld_q && same && run_q == RUN_HIT;
    cur_d = vld_q ? code_q : cur_q;
    run_d = !vld_q ? run_q : !same ? 8'd1 : (run_q == 8'hFF) ? run_q : run_q + 8'd1;
    last_d = last_q;
    cnt_d = cnt_q;
    s0_d = s0_q;
    s1_d = s1_q;
    s2_d = s2_q;
    if (start) begin
      run_d = 8'd0;
      last_d = 4'hF;
      cnt_d = 2'd0;
      s0_d = 4'hF;
      s1_d = 4'hF;
      s2_d = 4'hF;
    end else if (hit && cur_q == 4'hF) begin
      last_d = 4'hF;
    end else if (hit && cur_q != last_q && cnt_q != 2'd3) begin
      last_d = cur_q;
      cnt_d = cnt_q + 2'd1;
      s0_d = cnt_q == 2'd0 ? cur_q : s0_q;
      s1_d = cnt_q == 2'd1 ? cur_q : s1_q;
      s2_d = cnt_q == 2'd2 ? cur_q : s2_q;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      code_q <= 4'hF;
      cur_q <= 4'hF;
      last_q <= 4'hF;
      s0_q <= 4'hF;
      s1_q <= 4'hF;
      s2_q <= 4'hF;
      cnt_q <= 2'd0;
      run_q <= 8'd0;
      row_q <= 12'd0;
      col_q <= 12'd0;
      vld_q <= 1'b0;
      vde_q <= 1'b0;
      vs_q <= 1'b0;
      fl_q <= 1'b0;
      band0_o <= 4'hF;
      band1_o <= 4'hF;
      band2_o <= 4'hF;
      band_cnt_o <= 2'd0;
      valid_o <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q <= code_d;
      cur_q <= cur_d;
      last_q <= last_d;
      s0_q <= s0_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
      row_q <= row_d;
      col_q <= col_d;
      vld_q <= vld_d;
      vde_q <= vde_i;
      vs_q <= vsync_i;
      fl_q <= fl_d;
      valid_o <= state_q == REPORT;
      if (state_q == REPORT) begin
        band0_o <= s0_q;
        band1_o <= s1_q;
        band2_o <= s2_q;
        band_cnt_o <= cnt_q;
      end
    end
  end
endmodule

// File: tb/tb_band_scan.sv
// tb_band_scan: random and directed scan rows checked every cycle against a
// run-based reference model, plus literal expectations for directed rows.
module tb_band_scan;
  localparam int SR = 3;
  localparam int MR = 8;
  localparam logic [23:0] BG = 24'hF0F0F0, RED = 24'hFF3040, GREEN = 24'h2020C0,
    VIOLET = 24'hA0C040, BLUE = 24'h20C020, BLACK = 24'h101010, WHITE = 24'hC8C8C8,
    BROWN = 24'h601030, YELLOW = 24'hE020D0, ORANGE = 24'hF01080, GREY = 24'h808080;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [23:0] data = '0;
  logic vde = 1'b0, hsync = 1'b0, vsync = 1'b0;
  logic [3:0] b0, b1, b2;
  logic [1:0] bc;
  logic vo;
  int cyc = 0, n_chk = 0, n_fail = 0, pend_cyc = -1;
  logic [3:0] pend_b [3];
  logic [3:0] exp_b [3];
  logic [1:0] pend_cnt, exp_cnt;
  logic [23:0] row_px [$];
  logic [23:0] pal [11];

  band_scan #(.SCAN_ROW(SR), .MIN_RUN(MR)) dut (
    .clk(clk), .reset(reset), .data_i(data), .vde_i(vde), .hsync_i(hsync), .vsync_i(vsync),
    .band0_o(b0), .band1_o(b1), .band2_o(b2), .band_cnt_o(bc), .valid_o(vo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] classify(input logic [23:0] p);
    int r, g, b, lum, mx, mn;
    r = int'(p[23:16]);
    b = int'(p[15:8]);
    g = int'(p[7:0]);
    lum = (r + 2 * g + b) / 4;
    mx = (r > g) ? r : g;
    mx = (b > mx) ? b : mx;
    mn = (r < g) ? r : g;
    mn = (b < mn) ? b : mn;
    if (mx - mn < 32) return lum < 48 ? 4'd0 : lum < 160 ? 4'd8 : lum < 224 ? 4'd9 : 4'd15;
    if (r >= g && r >= b) return g >= r - 32 ? 4'd4 : g >= b + 48 ? 4'd3 : lum < 96 ? 4'd1 : 4'd2;
    if (g >= b) return 4'd5;
    return r >= g + 32 ? 4'd7 : 4'd6;
  endfunction

  // split the row into maximal same-code runs; every run of at least MR counts
  task automatic model();
    int i, j, n;
    logic [3:0] c, last;
    n = row_px.size();
    i = 0;
    last = 4'hF;
    pend_b = '{4'hF, 4'hF, 4'hF};
    pend_cnt = 2'd0;
    while (i < n) begin
      c = classify(row_px[i]);
      j = i;
      while (j < n && classify(row_px[j]) == c) j++;
      if (j - i >= MR) begin
        if (c == 4'hF) last = 4'hF;
        else if (c != last && pend_cnt < 2'd3) begin
          pend_b[pend_cnt] = c;
          pend_cnt = pend_cnt + 2'd1;
          last = c;
        end
      end
      i = j;
    end
  endtask

  task automatic check(input string nm, input logic [14:0] act, input logic [14:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got {b0,b1,b2,cnt,valid}=%h, expected %h", nm, cyc, act, want);
    end
  endtask

  task automatic lit(input string nm, input logic [3:0] e0, e1, e2, input logic [1:0] ec);
    check(nm, {b0, b1, b2, bc, vo}, {e0, e1, e2, ec, 1'b0});
  endtask

  initial forever begin
    logic expv;
    @(negedge clk);
    if (reset) begin
      exp_b = '{4'hF, 4'hF, 4'hF};
      exp_cnt = 2'd0;
    end
    expv = !reset && cyc == pend_cyc;
    if (expv) begin
      exp_b = pend_b;
      exp_cnt = pend_cnt;
    end
    check("cycle", {b0, b1, b2, bc, vo}, {exp_b[0], exp_b[1], exp_b[2], exp_cnt, expv});
  end

  task automatic tick(input logic v, input logic hs, input logic vs, input logic [23:0] d);
    @(negedge clk);
    vde = v;
    hsync = hs;
    vsync = vs;
    data = d;
  endtask

  task automatic seg(input logic [23:0] px, input int n);
    repeat (n) row_px.push_back(px);
  endtask

  task automatic frame(input int nlines, input int rst_at);
    repeat (2) tick(1'b0, 1'b0, 1'b1, '0);
    repeat (2) tick(1'b0, 1'b0, 1'b0, '0);
    for (int l = 0; l < nlines; l++) begin
      repeat (2) tick(1'b0, 1'b1, 1'b0, '0);
      repeat (2) tick(1'b0, 1'b0, 1'b0, '0);
      if (l == SR) begin
        for (int i = 0; i < row_px.size(); i++) begin
          if (i == rst_at) begin
            #2 reset = 1'b1;
            #1 lit("reset_immediate", 4'hF, 4'hF, 4'hF, 2'd0);
          end
          if (i == rst_at + 3) reset = 1'b0;
          tick(1'b1, 1'b0, 1'b0, row_px[i]);
        end
        tick(1'b0, 1'b0, 1'b0, '0);
        if (rst_at < 0) begin
          model();
          pend_cyc = cyc + 4;
        end
      end else repeat (16) tick(1'b1, 1'b0, 1'b0, 24'($urandom));
      repeat (6) tick(1'b0, 1'b0, 1'b0, '0);
    end
  endtask

  initial begin
    pal = '{BG, RED, GREEN, VIOLET, BLUE, BLACK, WHITE, BROWN, YELLOW, ORANGE, GREY};
    reset = 1'b1;
    repeat (3) @(negedge clk);
    lit("reset_state", 4'hF, 4'hF, 4'hF, 2'd0);
    reset = 1'b0;
    row_px.delete();
    seg(BG, 20); seg(RED, 12); seg(BG, 10); seg(GREEN, 12); seg(BG, 10); seg(VIOLET, 12); seg(BG, 10);
    frame(SR + 2, -1);
    lit("basic_three", 4'd2, 4'd5, 4'd7, 2'd3);
    row_px.delete();
    seg(BLUE, 20);
    frame(SR, -1);
    lit("short_frame_hold", 4'd2, 4'd5, 4'd7, 2'd3);
    frame(SR + 1, -1);
    lit("after_short", 4'd6, 4'hF, 4'hF, 2'd1);
    row_px.delete();
    seg(BROWN, 5); seg(BLACK, 20);
    frame(SR + 1, -1);
    lit("glitch", 4'd0, 4'hF, 4'hF, 2'd1);
    row_px.delete();
    seg(RED, 15); seg(BG, 10); seg(RED, 15);
    frame(SR + 1, -1);
    lit("repeat_gap", 4'd2, 4'd2, 4'hF, 2'd2);
    row_px.delete();
    seg(RED, 15); seg(WHITE, 3); seg(RED, 15);
    frame(SR + 1, -1);
    lit("repeat_nogap", 4'd2, 4'hF, 4'hF, 2'd1);
    row_px.delete();
    seg(RED, 10); seg(GREEN, 10); seg(BLUE, 10); seg(YELLOW, 10); seg(ORANGE, 10);
    frame(SR + 1, -1);
    lit("overflow", 4'd2, 4'd5, 4'd6, 2'd3);
    row_px.delete();
    seg(BG, 20); seg(GREEN, 8);
    frame(SR + 1, -1);
    lit("end_run_8", 4'd5, 4'hF, 4'hF, 2'd1);
    row_px.delete();
    seg(BG, 20); seg(GREEN, 7);
    frame(SR + 1, -1);
    lit("end_run_7", 4'hF, 4'hF, 4'hF, 2'd0);
    row_px.delete();
    seg(GREEN, 300);
    frame(SR + 1, -1);
    lit("saturate", 4'd5, 4'hF, 4'hF, 2'd1);
    row_px.delete();
    seg(RED, 12); seg(BG, 12); seg(GREEN, 12); seg(BG, 30);
    frame(SR + 1, 45);
    lit("reset_frame", 4'hF, 4'hF, 4'hF, 2'd0);
    frame(SR + 1, -1);
    lit("after_reset", 4'd2, 4'd5, 4'hF, 2'd2);
    for (int f = 0; f < 30; f++) begin
      row_px.delete();
      while (row_px.size() < 120) begin
        int k;
        k = int'($urandom_range(0, 11));
        seg(k == 11 ? 24'($urandom) : pal[k], int'($urandom_range(1, 20)));
      end
      frame(($urandom_range(0, 4) == 0) ? int'($urandom_range(1, SR)) : SR + int'($urandom_range(1, 2)), -1);
    end
    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
